// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory access controller.
// Build option: DMEM_ALIGN_CHECK_EN (see dmem_addr_check).
package dmem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int WORD_LSB  = 2;
  localparam int MEM_DEPTH = 256;

  // Address bits at and above RANGE_LSB must be zero to land inside the
  // memory; for a 256-word memory with word index addr[9:2] this is 15:10.
  localparam int RANGE_LSB = WORD_LSB + $clog2(MEM_DEPTH);
  localparam int RANGE_MSB = ADDR_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Core-side request/response channels of the data-memory access controller.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. Once valid is raised, the sender holds valid and its payload
// unchanged until that edge; ready may change freely and does not depend on
// valid.
interface dmem_access_ctrl_if
  import dmem_pkg::*;
();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // Core pipeline side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_addr_check.sv
// Combinational address-fault decode for the data-memory access controller.
// Build option: DMEM_ALIGN_CHECK_EN adds a word-alignment fault.
module dmem_addr_check
  import dmem_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic              fault
);

  logic range_fault;

  // Anything above the top word of the 256-word memory is a fault.
  assign range_fault = (addr[RANGE_MSB:RANGE_LSB] != '0);

`ifdef DMEM_ALIGN_CHECK_EN
  logic align_fault;
  logic unused_word_idx;

  // A byte offset inside the word is rejected when alignment is enforced.
  assign align_fault     = (addr[WORD_LSB-1:0] != '0);
  assign fault           = range_fault | align_fault;
  assign unused_word_idx = ^addr[RANGE_LSB-1:WORD_LSB];
`else
  logic unused_low_bits;

  // Byte offset is ignored: the access goes to word addr[9:2].
  assign fault           = range_fault;
  assign unused_low_bits = ^addr[RANGE_LSB-1:0];
`endif

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator between the core pipeline and data_memory.
// One word request at a time; loads return captured read data, stores return
// zero, faulting addresses return resp_err without touching memory.
// Build option: DMEM_ALIGN_CHECK_EN (passed through to dmem_addr_check).
module dmem_access_ctrl
  import dmem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  dmem_access_ctrl_if.slave    core,
  output logic [ADDR_W-1:0]    mem_access_addr,
  output logic [DATA_W-1:0]    mem_write_data,
  output logic                 mem_write_en,
  output logic                 mem_read,
  input  logic [DATA_W-1:0]    mem_read_data,
  output state_t               dbg_state
);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              addr_fault;

  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              req_we_q;

  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  dmem_addr_check u_addr_check (
    .addr  (core.req_addr),
    .fault (addr_fault)
  );

  // Next-state decode; a request is taken only while idle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          accept = 1'b1;
          if (addr_fault) begin
            state_d = ST_RESP;
          end else if (core.req_we) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (core.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request registers hold the accepted request for the memory cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
    end else if (accept) begin
      req_addr_q  <= core.req_addr;
      req_wdata_q <= core.req_wdata;
      req_we_q    <= core.req_we;
    end
  end

  // Response registers: fault flag set at accept, data set by the memory
  // cycle, both cleared once the core has taken the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            resp_rdata_q <= '0;
            resp_err_q   <= addr_fault;
          end
        end
        ST_READ:  resp_rdata_q <= mem_read_data;
        ST_WRITE: resp_rdata_q <= '0;
        ST_RESP: begin
          if (core.resp_ready) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Strobes and handshake flags decode from the state register alone, so
  // they can never overlap and fall as soon as reset is asserted.
  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = (state_q == ST_RESP);
  assign core.resp_rdata = resp_rdata_q;
  assign core.resp_err   = resp_err_q;

  assign mem_read        = (state_q == ST_READ);
  assign mem_write_en    = (state_q == ST_WRITE);
  assign mem_access_addr = req_addr_q;
  assign mem_write_data  = req_wdata_q;

  assign dbg_state       = state_q;

  // The stored direction is implied by READ/WRITE; kept for debug visibility.
  logic unused_we;
  assign unused_we = req_we_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural memory.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();

  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        mem_write_en;
  logic        mem_read;
  state_t      dbg_state;

  dmem_access_ctrl dut (
    .clk             (clk),
    .reset           (rst_n),
    .core            (bus),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data),
    .dbg_state       (dbg_state)
  );

  // ---------------- bench memory (stand-in for data_memory) ----------------
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];

  assign mem_read_data = mem[mem_access_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[9:2]] <= mem_write_data;
  end

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic bit addr_faults(input logic [15:0] a);
    bit f;
    f = (a[15:10] != 6'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    f = f || (a[1:0] != 2'd0);
`endif
    return f;
  endfunction

  logic [16:0] exp_q[$];   // {err, rdata} of the outstanding response
  bit          m_busy = 1'b0;
  bit          m_load = 1'b0;
  bit          m_err  = 1'b0;
  int          m_acc  = 0;
  int          m_resp_start = 0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  int          edge_cnt = 0;

  // Model: a transaction is accepted on an edge where none is outstanding;
  // its strobe occupies the cycle after acceptance, the response is offered
  // from the next cycle (or immediately after acceptance for a fault) and
  // retires on the first edge with resp_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else begin
      edge_cnt++;
      if (m_busy) begin
        if (!m_load && !m_err && edge_cnt == m_acc + 1)
          ref_mem[m_addr[9:2]] = m_wdata;
        if (edge_cnt > m_resp_start && bus.resp_ready) begin
          m_busy = 1'b0;
          void'(exp_q.pop_front());
        end
      end else if (bus.req_valid) begin
        m_busy       = 1'b1;
        m_acc        = edge_cnt;
        m_load       = !bus.req_we;
        m_addr       = bus.req_addr;
        m_wdata      = bus.req_wdata;
        m_err        = addr_faults(bus.req_addr);
        m_resp_start = m_acc + (m_err ? 0 : 1);
        exp_q.push_back({m_err, (m_err || !m_load) ? 16'h0000 : ref_mem[bus.req_addr[9:2]]});
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    bit exp_rv, exp_rd, exp_wr;
    if (!rst_n) begin
      check("rst_req_ready",  32'(bus.req_ready),  32'd1);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_err",   32'(bus.resp_err),   32'd0);
      check("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
      check("rst_mem_read",   32'(mem_read),       32'd0);
      check("rst_mem_we",     32'(mem_write_en),   32'd0);
      check("rst_mem_addr",   32'(mem_access_addr), 32'd0);
      check("rst_mem_wdata",  32'(mem_write_data), 32'd0);
      check("rst_state",      32'(dbg_state),      32'(ST_IDLE));
    end else begin
      exp_rv = m_busy && (edge_cnt >= m_resp_start);
      exp_rd = m_busy && m_load && !m_err && (edge_cnt == m_acc);
      exp_wr = m_busy && !m_load && !m_err && (edge_cnt == m_acc);
      check("req_ready",  32'(bus.req_ready),  32'(!m_busy));
      check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      check("mem_read",   32'(mem_read),       32'(exp_rd));
      check("mem_write_en", 32'(mem_write_en), 32'(exp_wr));
      if (exp_rd || exp_wr) check("mem_addr", 32'(mem_access_addr), 32'(m_addr));
      if (exp_wr)           check("mem_wdata", 32'(mem_write_data), 32'(m_wdata));
      if (exp_rv && exp_q.size() > 0)
        check("resp_payload", 32'({bus.resp_err, bus.resp_rdata}), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", 32'(waited < 20), 32'd1);
  endtask

  task automatic wait_resp(output int lat, output int rd_p, output int wr_p);
    lat = 0; rd_p = 0; wr_p = 0;
    do begin
      @(negedge clk);
      lat++;
      rd_p += int'(mem_read);
      wr_p += int'(mem_write_en);
    end while (!bus.resp_valid && lat < 20);
    check("resp_timeout", 32'(lat < 20), 32'd1);
  endtask

  task automatic xact(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                      input int hold, output logic [15:0] rdata, output bit err,
                      output int lat, output int rd_p, output int wr_p);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    wait_ready();
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_resp(lat, rd_p, wr_p);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rd;
    bit          er;
    int          lat, rp, wp;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'hA000 + 16'(i);
      ref_mem[i] = 16'hA000 + 16'(i);
    end
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Store 0x0010 <- 0xBEEF
    xact(1'b1, 16'h0010, 16'hBEEF, 0, rd, er, lat, rp, wp);
    check("st_lat",   32'(lat), 32'd2);
    check("st_wr_p",  32'(wp),  32'd1);
    check("st_rd_p",  32'(rp),  32'd0);
    check("st_err",   32'(er),  32'd0);
    check("st_rdata", 32'(rd),  32'h0000);
    check("st_mem4",  32'(mem[4]), 32'hBEEF);

    // Load 0x0010
    xact(1'b0, 16'h0010, 16'h0000, 0, rd, er, lat, rp, wp);
    check("ld_lat",   32'(lat), 32'd2);
    check("ld_rd_p",  32'(rp),  32'd1);
    check("ld_wr_p",  32'(wp),  32'd0);
    check("ld_err",   32'(er),  32'd0);
    check("ld_rdata", 32'(rd),  32'hBEEF);

    // Load 0x0400: out of range
    xact(1'b0, 16'h0400, 16'h0000, 0, rd, er, lat, rp, wp);
    check("flt_lat",   32'(lat), 32'd1);
    check("flt_pulse", 32'(rp + wp), 32'd0);
    check("flt_err",   32'(er),  32'd1);
    check("flt_rdata", 32'(rd),  32'h0000);

    // Load 0x0012: misaligned
    xact(1'b0, 16'h0012, 16'h0000, 0, rd, er, lat, rp, wp);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_err",   32'(er),  32'd1);
    check("mis_rdata", 32'(rd),  32'h0000);
    check("mis_lat",   32'(lat), 32'd1);
`else
    check("mis_err",   32'(er),  32'd0);
    check("mis_rdata", 32'(rd),  32'hBEEF);
    check("mis_lat",   32'(lat), 32'd2);
`endif

    // Top word, then a faulting store that must not write
    xact(1'b1, 16'h03FC, 16'h5A5A, 0, rd, er, lat, rp, wp);
    check("top_st_err", 32'(er), 32'd0);
    xact(1'b0, 16'h03FC, 16'h0000, 1, rd, er, lat, rp, wp);
    check("top_ld_rdata", 32'(rd), 32'h5A5A);
    xact(1'b1, 16'h8000, 16'h1111, 0, rd, er, lat, rp, wp);
    check("flt_st_err",  32'(er), 32'd1);
    check("flt_st_wr_p", 32'(wp), 32'd0);
    check("flt_st_mem0", 32'(mem[0]), 32'hA000);

    // Response held for 5 cycles with the next request pending
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0010;
    wait_ready();
    @(posedge clk);
    #1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0014;
    bus.req_wdata = 16'hCAFE;
    wait_resp(lat, rp, wp);
    for (int i = 0; i < 5; i++) begin
      check("hold_req_ready", 32'(bus.req_ready),  32'd0);
      check("hold_valid",     32'(bus.resp_valid), 32'd1);
      check("hold_rdata",     32'(bus.resp_rdata), 32'hBEEF);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    check("pend_not_yet", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    check("pend_accept_next", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("pend_store_strobe", 32'(mem_write_en), 32'd1);
    check("pend_store_addr",   32'(mem_access_addr), 32'h0014);
    wait_resp(lat, rp, wp);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check("pend_mem5", 32'(mem[5]), 32'hCAFE);

    // Reset asserted during WRITE
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_wdata = 16'h1234;
    wait_ready();
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstw_we",        32'(mem_write_en),   32'd0);
    check("rstw_req_ready", 32'(bus.req_ready),  32'd1);
    check("rstw_resp_vld",  32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("rstw_mem8", 32'(mem[8]), 32'hA008);
    xact(1'b0, 16'h0020, 16'h0000, 0, rd, er, lat, rp, wp);
    check("rstw_ld_rdata", 32'(rd),  32'hA008);
    check("rstw_ld_lat",   32'(lat), 32'd2);
    xact(1'b1, 16'h0020, 16'h7777, 2, rd, er, lat, rp, wp);
    check("rstw_st_mem8", 32'(mem[8]), 32'h7777);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #100000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
